dmem_responder: RTL and testbench

- Data-memory responder for the MEM stage: accepts load/store requests issued by MEM, serves them from an internal word-addressed array after a configurable wait, and drives the ready that advances the MEM/WB pipeline register.
- Performs RV32I load sign/zero extension and store byte-lane masking from funct3.
- Flags misaligned and conflicting requests.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 36 +++
 rtl/dmem_responder.sv | 135 +++++++++++++
 tb/tb_dmem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, responder FSM states and access legality helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        return is_store ? (f3 inside {F3_B, F3_H, F3_W})
                        : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores and sign/zero extension for loads.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] raw_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = raw_i[8*off_i +: 8];
    assign half_sel = off_i[1] ? raw_i[31:16] : raw_i[15:0];

    assign be_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << off_i :
                  funct3_i[1:0] == 2'b01 ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;

    // Replicating the right-aligned data lets the byte enables pick the lane.
    assign wdata_o = funct3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                     funct3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;

    assign rdata_o = funct3_i == F3_B  ? {{24{byte_sel[7]}}, byte_sel} :
                     funct3_i == F3_BU ? {24'b0, byte_sel} :
                     funct3_i == F3_H  ? {{16{half_sel[15]}}, half_sel} :
                     funct3_i == F3_HU ? {16'b0, half_sel} :
                     funct3_i == F3_W  ? raw_i : '0;

    assign misalign_o = misaligned(funct3_i, off_i);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with fixed wait, RV32I lane handling and error flagging.
// Define DMEM_PERF_CNT_EN to enable the completed load/store counters on rd_cnt/wr_cnt.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic          rd_q, wr_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH];

    logic [3:0]    be;
    logic [31:0]   wshift, rext;
    logic          misalign, err, access;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    dmem_lane_align u_align (
        .funct3_i   (f3_q),
        .off_i      (addr_q[1:0]),
        .raw_i      (mem_q[addr_q[AW+1:2]]),
        .wdata_i    (wdata_q),
        .be_o       (be),
        .wdata_o    (wshift),
        .rdata_o    (rext),
        .misalign_o (misalign)
    );

    assign err    = (rd_q == wr_q) | ~f3_legal(f3_q, wr_q) | misalign;
    assign access = state_q == BUSY && cnt_q == 4'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && req_valid) begin
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                rd_q    <= req_read;
                wr_q    <= req_write;
            end
            if (access) begin
                rdata_q <= (err || wr_q) ? '0 : rext;
                err_q   <= err;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = BUSY;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            BUSY: if (cnt_q == 4'd0) state_d = DONE;
                  else cnt_d = cnt_q - 4'd1;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state_q == IDLE;
        rsp_valid = state_q == DONE;
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Async reset forces IDLE, so an aborted store never reaches this write.
    always_ff @(posedge clk) begin
        if (access && !err && wr_q)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[addr_q[AW+1:2]][8*i +: 8] <= wshift[8*i +: 8];
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (state_q == DONE && !err_q) begin
            rd_cnt_q <= rd_cnt_q + 32'(rd_q);
            wr_cnt_q <= wr_cnt_q + 32'(wr_q);
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`else
    assign rd_cnt = '0;
    assign wr_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-level memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 64;
    localparam int W     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, rd_cnt, wr_cnt;

    int n_chk = 0, n_fail = 0, n_rd = 0, n_wr = 0, cyc = 0, rsp_cyc = 0;
    logic [31:0] mem_m [DEPTH];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef DMEM_PERF_CNT_EN
        return 32'(n);
`else
        return 32'(0) & 32'(n);
`endif
    endfunction

    // Reference: byte-granular view of the memory, rules applied directly.
    task automatic model_op(input logic r, w, input logic [31:0] a, d, input logic [2:0] f,
                            output logic [31:0] er, output logic ee);
        int o, sz, wi;
        logic [31:0] v;
        bit ld_ok, st_ok;
        o  = int'(a % 4);
        wi = int'((a / 4) % DEPTH);
        sz = 1 << (f % 4);
        ld_ok = f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        st_ok = f <= 3'd2;
        ee = (r == w) || (r && !ld_ok) || (w && !st_ok) || (o % sz != 0);
        er = 0;
        if (!ee && r) begin
            v = 0;
            for (int k = 0; k < sz; k++) v[8*k +: 8] = mem_m[wi][8*(o+k) +: 8];
            if (f < 4 && v[8*sz-1]) for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
            er = v;
            n_rd++;
        end
        if (!ee && w) begin
            for (int k = 0; k < sz; k++) mem_m[wi][8*(o+k) +: 8] = d[8*k +: 8];
            n_wr++;
        end
    endtask

    // Called at a negedge; returns at the negedge where rsp_valid was seen.
    task automatic do_req(input logic r, w, input logic [31:0] a, d, input logic [2:0] f,
                          output logic [31:0] rdata, output logic err, output int lat);
        int g = 0;
        while (!req_ready && g < 50) begin @(negedge clk); g++; end
        req_valid = 1; req_read = r; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
        if (!rsp_valid) lat = -1;
        rsp_cyc = cyc;
        rdata = rsp_rdata;
        err = rsp_err;
        req_valid = 0; req_read = 0; req_write = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        n_rd = 0; n_wr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_chk += 6;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", rsp_err); end
        if (rd_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_rd_cnt: got %h want 0", rd_cnt); end
        if (wr_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_wr_cnt: got %h want 0", wr_cnt); end
    endtask

    task automatic test_init();
        logic [31:0] rd, er_m, d; logic e, ee_m; int lat;
        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom();
            do_req(0, 1, 32'(i * 4), d, F3_W, rd, e, lat);
            model_op(0, 1, 32'(i * 4), d, F3_W, er_m, ee_m);
            n_chk++;
            if (e !== 1'b0 || lat != W + 2) begin
                n_fail++; $display("FAIL init_sw[%0d]: got err=%b lat=%0d want err=0 lat=%0d", i, e, lat, W + 2);
            end
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, er_m; logic e, ee_m; int lat;
        do_req(0, 1, 32'h10, 32'hDEADBEEF, F3_W, rd, e, lat);
        model_op(0, 1, 32'h10, 32'hDEADBEEF, F3_W, er_m, ee_m);
        do_req(1, 0, 32'h10, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h10, 0, F3_W, er_m, ee_m);
        n_chk += 3;
        if (lat != W + 2) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", lat, W + 2); end
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
        if (e !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b want 0", e); end
    endtask

    task automatic test_extension();
        logic [31:0] rd, er_m; logic e, ee_m; int lat;
        logic [31:0] ta [4] = '{32'h22, 32'h23, 32'h22, 32'h20};
        logic [2:0]  tf [4] = '{F3_B, F3_BU, F3_H, F3_HU};
        logic [31:0] te [4] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
        do_req(0, 1, 32'h20, 32'h80FF7F01, F3_W, rd, e, lat);
        model_op(0, 1, 32'h20, 32'h80FF7F01, F3_W, er_m, ee_m);
        for (int i = 0; i < 4; i++) begin
            do_req(1, 0, ta[i], 0, tf[i], rd, e, lat);
            model_op(1, 0, ta[i], 0, tf[i], er_m, ee_m);
            n_chk++;
            if (rd !== te[i] || e !== 1'b0) begin
                n_fail++; $display("FAIL ext[%0d]: got %h err=%b want %h err=0", i, rd, e, te[i]);
            end
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd, er_m; logic e, ee_m; int lat;
        do_req(0, 1, 32'h30, 32'h11223344, F3_W, rd, e, lat);
        model_op(0, 1, 32'h30, 32'h11223344, F3_W, er_m, ee_m);
        do_req(0, 1, 32'h31, 32'h555555AA, F3_B, rd, e, lat);
        model_op(0, 1, 32'h31, 32'h555555AA, F3_B, er_m, ee_m);
        do_req(0, 1, 32'h32, 32'h6666BEEF, F3_H, rd, e, lat);
        model_op(0, 1, 32'h32, 32'h6666BEEF, F3_H, er_m, ee_m);
        n_chk++;
        if (rd !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL sh_rsp: got %h err=%b want 0 err=0", rd, e); end
        do_req(1, 0, 32'h30, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h30, 0, F3_W, er_m, ee_m);
        n_chk++;
        if (rd !== 32'hBEEFAA44) begin n_fail++; $display("FAIL lanes: got %h want beefaa44", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, er_m; logic e, ee_m; int lat;
        logic       tr [7] = '{1, 0, 1, 1, 0, 0, 1};
        logic       tw [7] = '{0, 1, 1, 0, 0, 1, 0};
        logic [31:0] ta [7] = '{32'h31, 32'h33, 32'h30, 32'h30, 32'h30, 32'h30, 32'h31};
        logic [2:0]  tf [7] = '{F3_W, F3_H, F3_W, 3'b011, F3_W, F3_BU, F3_H};
        for (int i = 0; i < 7; i++) begin
            do_req(tr[i], tw[i], ta[i], 32'hCAFEF00D, tf[i], rd, e, lat);
            model_op(tr[i], tw[i], ta[i], 32'hCAFEF00D, tf[i], er_m, ee_m);
            n_chk++;
            if (e !== 1'b1 || rd !== 32'h0 || lat != W + 2) begin
                n_fail++; $display("FAIL err[%0d]: got err=%b rdata=%h lat=%0d want err=1 rdata=0", i, e, rd, lat);
            end
        end
        do_req(1, 0, 32'h30, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h30, 0, F3_W, er_m, ee_m);
        n_chk++;
        if (rd !== 32'hBEEFAA44 || e !== 1'b0) begin n_fail++; $display("FAIL err_nowrite: got %h want beefaa44", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, er_m; logic e, ee_m; int lat, t0, bad;
        do_req(1, 0, 32'h10, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h10, 0, F3_W, er_m, ee_m);
        t0 = rsp_cyc;
        do_req(1, 0, 32'h20, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h20, 0, F3_W, er_m, ee_m);
        n_chk++;
        if (rsp_cyc - t0 != W + 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", rsp_cyc - t0, W + 3); end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h80FF7F01) bad++;
        end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL hold: got %0d bad cycles, rdata=%h want 0 and 80ff7f01", bad, rsp_rdata); end
    endtask

    task automatic test_random();
        logic [31:0] rd, er_m, a, d; logic e, ee_m, r, w; logic [2:0] f; int lat, s;
        logic [2:0] legal [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int i = 0; i < 150; i++) begin
            s = int'($urandom_range(0, 9));
            r = (s == 0) || (s >= 2 && s < 6);
            w = (s == 0) || (s >= 6);
            a = $urandom();
            d = $urandom();
            f = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
            do_req(r, w, a, d, f, rd, e, lat);
            model_op(r, w, a, d, f, er_m, ee_m);
            n_chk++;
            if (rd !== er_m || e !== ee_m || lat != W + 2) begin
                n_fail++;
                $display("FAIL rand[%0d] r=%b w=%b a=%h f=%0d: got %h err=%b lat=%0d want %h err=%b lat=%0d",
                         i, r, w, a, f, rd, e, lat, er_m, ee_m, W + 2);
            end
        end
        @(negedge clk);
        n_chk += 2;
        if (rd_cnt !== exp_cnt(n_rd)) begin n_fail++; $display("FAIL rand_rd_cnt: got %h want %h", rd_cnt, exp_cnt(n_rd)); end
        if (wr_cnt !== exp_cnt(n_wr)) begin n_fail++; $display("FAIL rand_wr_cnt: got %h want %h", wr_cnt, exp_cnt(n_wr)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, er_m; logic e, ee_m; int lat, bad;
        req_valid = 1; req_read = 0; req_write = 1; req_addr = 32'h40; req_wdata = 32'h12345678; req_funct3 = F3_W;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got ready=%b want 0", req_ready); end
        rst = 0;
        #1;
        n_chk++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
        end
        req_valid = 0; req_write = 0;
        bad = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0) bad++; end
        rst = 1;
        n_rd = 0; n_wr = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++; end
        n_chk++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_no_rsp: got %0d bad cycles want 0", bad); end
        do_req(1, 0, 32'h40, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h40, 0, F3_W, er_m, ee_m);
        n_chk++;
        if (rd !== er_m || e !== 1'b0) begin n_fail++; $display("FAIL mid_nowrite: got %h want %h", rd, er_m); end
    endtask

    task automatic test_counters();
        logic [31:0] rd, er_m; logic e, ee_m; int lat;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            do_req(0, 1, 32'(8 + 4 * i), 32'(i + 1), F3_W, rd, e, lat);
            model_op(0, 1, 32'(8 + 4 * i), 32'(i + 1), F3_W, er_m, ee_m);
        end
        for (int i = 0; i < 3; i++) begin
            do_req(1, 0, 32'(8 + i), 0, F3_BU, rd, e, lat);
            model_op(1, 0, 32'(8 + i), 0, F3_BU, er_m, ee_m);
        end
        do_req(1, 0, 32'h61, 0, F3_W, rd, e, lat);
        model_op(1, 0, 32'h61, 0, F3_W, er_m, ee_m);
        @(negedge clk);
        n_chk += 2;
`ifdef DMEM_PERF_CNT_EN
        if (rd_cnt !== 32'd3) begin n_fail++; $display("FAIL cnt_rd: got %h want 3", rd_cnt); end
        if (wr_cnt !== 32'd2) begin n_fail++; $display("FAIL cnt_wr: got %h want 2", wr_cnt); end
`else
        if (rd_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_rd: got %h want 0", rd_cnt); end
        if (wr_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wr: got %h want 0", wr_cnt); end
`endif
    endtask

    initial begin
        rst = 0;
        req_valid = 0; req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        @(negedge clk);
        test_reset();
        test_init();
        test_latency();
        test_extension();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_counters();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
